// File: rtl/instruction_memory.sv
// Instruction memory with a combinational fetch port and a clocked program-load write port.
// A boot image is present at power-up. Reset masks the outputs and blocks writes, but it never touches the stored words.
module instruction_memory #(
   parameter int unsigned DEPTH       = 256,
   parameter logic [31:0] RESET_INSTR = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   output logic [31:0] instr,
   input  logic        we,
   input  logic [31:0] waddr,
   input  logic [31:0] wdata,
   output logic        misaligned,
   output logic        out_of_range
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h00000013;

   // Boot program; every word it does not name holds a NOP.
   logic [31:0] r_mem [DEPTH] = '{
      0:       32'h00500093,
      1:       32'h00A00113,
      2:       32'h002081B3,
      3:       32'h40208233,
      4:       32'h0041A023,
      default: NOP
   };

   logic [AW-1:0] w_rdIdx;
   logic [AW-1:0] w_wrIdx;
   logic          w_rdInRange;
   logic          w_wrInRange;
   logic          w_wrEn;

   // DEPTH is a power of two, so a word index is in range exactly when every bit above the index field is zero.
   assign w_rdIdx     = addr[AW+1:2];
   assign w_wrIdx     = waddr[AW+1:2];
   assign w_rdInRange = (addr[31:AW+2] == '0);
   assign w_wrInRange = (waddr[31:AW+2] == '0);
   assign w_wrEn      = rst & we & (waddr[1:0] == 2'b00) & w_wrInRange;

   always_ff @(posedge clk) begin
      if (w_wrEn) begin
         r_mem[w_wrIdx] <= wdata;
      end
   end

   always_comb begin
      instr        = RESET_INSTR;
      misaligned   = 1'b0;
      out_of_range = 1'b0;
      if (rst) begin
         misaligned   = (addr[1:0] != 2'b00);
         out_of_range = !w_rdInRange;
         instr        = w_rdInRange ? r_mem[w_rdIdx] : NOP;
      end
   end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: the stimulus pushes predictions from an array model,
// and a separate monitor compares them on each sample strobe.
module tb_instruction_memory;

   localparam int unsigned DEPTH       = 256;
   localparam logic [31:0] RESET_INSTR = 32'h00000000;
   localparam logic [31:0] NOP         = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] instr;
   logic        we = 1'b0;
   logic [31:0] waddr = '0;
   logic [31:0] wdata = '0;
   logic        misaligned;
   logic        out_of_range;
   logic        sampleStrobe = 1'b0;

   int assertCount = 0;
   int errorCount  = 0;

   typedef struct {
      logic [31:0] instr;
      logic        mis;
      logic        oor;
      string       name;
   } expect_t;

   expect_t     scoreQ[$];
   logic [31:0] refMem [DEPTH];

   instruction_memory #(
      .DEPTH(DEPTH),
      .RESET_INSTR(RESET_INSTR)
   ) dut (
      .clk(clk),
      .rst(rst),
      .addr(addr),
      .instr(instr),
      .we(we),
      .waddr(waddr),
      .wdata(wdata),
      .misaligned(misaligned),
      .out_of_range(out_of_range)
   );

   always #5 clk = ~clk;

   // The model works from plain byte-address arithmetic on a word array.
   function automatic expect_t predict(input logic [31:0] a, input string name);
      expect_t e;
      e.name = name;
      if (!rst) begin
         e.instr = RESET_INSTR;
         e.mis   = 1'b0;
         e.oor   = 1'b0;
      end else begin
         e.mis   = (a % 4) != 0;
         e.oor   = (a / 4) >= DEPTH;
         e.instr = e.oor ? NOP : refMem[a / 4];
      end
      return e;
   endfunction

   function automatic void modelWrite(input logic [31:0] wa, input logic [31:0] wd);
      if (rst && (wa % 4) == 0 && (wa / 4) < DEPTH) begin
         refMem[wa / 4] = wd;
      end
   endfunction

   task automatic sampleNow(input string name);
      #1;
      scoreQ.push_back(predict(addr, name));
      sampleStrobe = 1'b1;
      #1;
      sampleStrobe = 1'b0;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input string name);
      @(negedge clk);
      addr = a;
      sampleNow(name);
   endtask

   // The read address follows the write address, so the sample just after the edge shows whether the write is visible.
   task automatic doWrite(input logic [31:0] wa, input logic [31:0] wd, input string name);
      @(negedge clk);
      we    = 1'b1;
      waddr = wa;
      wdata = wd;
      addr  = wa;
      @(posedge clk);
      modelWrite(wa, wd);
      #1;
      we = 1'b0;
      sampleNow(name);
   endtask

   task automatic checkOutput();
      expect_t e;
      if (scoreQ.size() == 0) begin
         assertCount++;
         errorCount++;
         $display("[TB] FAIL underflow: sample strobe with empty scoreboard");
      end else begin
         e = scoreQ.pop_front();
         assertCount++;
         if (instr !== e.instr) begin
            errorCount++;
            $display("[TB] FAIL %s instr: got %h expected %h (addr %h)", e.name, instr, e.instr, addr);
         end
         assertCount++;
         if (misaligned !== e.mis) begin
            errorCount++;
            $display("[TB] FAIL %s misaligned: got %b expected %b (addr %h)", e.name, misaligned, e.mis, addr);
         end
         assertCount++;
         if (out_of_range !== e.oor) begin
            errorCount++;
            $display("[TB] FAIL %s out_of_range: got %b expected %b (addr %h)", e.name, out_of_range, e.oor, addr);
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge sampleStrobe);
         checkOutput();
      end
   end

   function automatic logic [31:0] pickAddr();
      int k;
      k = $urandom_range(0, 9);
      case (k)
         0:       return 32'($urandom_range(0, DEPTH * 4 - 1));
         1:       return 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
         2:       return $urandom;
         default: return 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      for (int i = 0; i < DEPTH; i++) refMem[i] = NOP;
      refMem[0] = 32'h00500093;
      refMem[1] = 32'h00A00113;
      refMem[2] = 32'h002081B3;
      refMem[3] = 32'h40208233;
      refMem[4] = 32'h0041A023;

      applyStimulus(32'h0000_0000, "reset_addr0");
      applyStimulus(32'h0000_0407, "reset_oor_mis");
      applyStimulus($urandom, "reset_rand");

      @(negedge clk);
      rst = 1'b1;
      addr = 32'h0;
      sampleNow("release_word0");

      applyStimulus(32'h04, "seq_word1");
      applyStimulus(32'h08, "seq_word2");
      applyStimulus(32'h0C, "seq_word3");
      applyStimulus(32'h10, "seq_word4");
      applyStimulus(32'h04, "revisit_word1");
      applyStimulus(32'h0C, "revisit_word3");
      applyStimulus(32'h06, "misaligned_06");
      applyStimulus(32'h400, "oor_depth");
      applyStimulus(32'h403, "oor_and_mis");
      applyStimulus(32'h3FC, "last_word");

      doWrite(32'h14, 32'hDEADBEEF, "write_word5");
      applyStimulus(32'h14, "read_word5");
      doWrite(32'h15, 32'hCAFEF00D, "write_misaligned");
      applyStimulus(32'h14, "word5_kept");
      doWrite(32'h400, 32'h11112222, "write_oor");

      @(negedge clk);
      rst  = 1'b0;
      addr = 32'h14;
      sampleNow("rst_pulse");
      doWrite(32'h14, 32'h12345678, "write_in_reset");
      @(negedge clk);
      rst  = 1'b1;
      addr = 32'h14;
      sampleNow("after_release");

      for (int i = 0; i < 120; i++) begin
         a = pickAddr();
         if ($urandom_range(0, 3) == 0) begin
            d = $urandom;
            doWrite(a, d, "rand_write");
         end else begin
            applyStimulus(a, "rand_read");
         end
      end

      for (int i = 0; i < 50 && scoreQ.size() != 0; i++) #1;
      if (scoreQ.size() != 0) begin
         assertCount++;
         errorCount++;
         $display("[TB] FAIL drain: %0d predictions left unchecked, required 0", scoreQ.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, errorCount);
      $finish;
   end

endmodule
